rr_fifo_scheduler: RTL and testbench

- Moves 10-bit words from four input FIFOs (0-3) to four output FIFOs (4-7).
- Selects among non-empty inputs with a round-robin arbiter and routes each word by its two MSBs.
- Pauses with hysteresis on the output-FIFO occupancy thresholds `alto` and `bajo`.
- Keeps per-output delivered-word counters, readable through a `req`/`idx` interface.

---
 rtl/rr_fifo_scheduler_if.sv | 24 ++
 rtl/rr_fifo_scheduler.sv | 155 +++++++++++++++
 tb/tb_rr_fifo_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_fifo_scheduler_if.sv
// FIFO-side bundle of the round-robin scheduler: four input FIFOs (read side)
// and four output FIFOs (write side) grouped behind master/slave modports.
interface rr_fifo_scheduler_if #(
  parameter int DATA_W = 10,
  parameter int LVL_W  = 4
);
  logic [3:0]          in_empty;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_pop;
  logic [4*LVL_W-1:0]  out_level;
  logic [3:0]          out_full;
  logic [3:0]          out_push;
  logic [DATA_W-1:0]   out_data;

  modport master (
    input  in_empty, in_data, out_level, out_full,
    output in_pop, out_push, out_data
  );

  modport slave (
    output in_empty, in_data, out_level, out_full,
    input  in_pop, out_push, out_data
  );
endinterface

// File: rtl/rr_fifo_scheduler.sv
// Round-robin mover from input FIFOs 0-3 to output FIFOs 4-7 with watermark
// hysteresis, a fixed two-cycle pipeline and per-output delivered-word counters.
module rr_fifo_scheduler #(
  parameter int DATA_W = 10,
  parameter int LVL_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [2:0]          alto,
  input  logic [2:0]          bajo,
  rr_fifo_scheduler_if.master bus,
  input  logic                req,
  input  logic [1:0]          idx,
  output logic [CNT_W-1:0]    cnt,
  output logic                cnt_valid,
  output logic                idle,
  output logic                err,
  output logic [3:0]          estado_actual
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_INIT   = 4'd1,
    ST_IDLE   = 4'd2,
    ST_ACTIVE = 4'd3,
    ST_PAUSE  = 4'd4
  } state_t;

  state_t            state;
  logic [1:0]        ptr;
  logic [2:0]        alto_q;
  logic [2:0]        bajo_q;
  logic              p1_valid;
  logic [1:0]        p1_idx;
  logic [3:0]        push_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count [4];

  logic              any_high;
  logic              all_low;
  logic              any_ready;
  logic              in_flight;
  logic              pop_en;
  logic              found;
  logic [1:0]        cand;
  logic [1:0]        grant_idx;
  logic [3:0]        grant;
  logic [DATA_W-1:0] word_in;
  logic [1:0]        dest_in;
  logic [1:0]        dest_out;

  always_comb begin
    any_high = 1'b0;
    all_low  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (bus.out_level[j*LVL_W +: LVL_W] >= LVL_W'(alto_q)) any_high = 1'b1;
      if (bus.out_level[j*LVL_W +: LVL_W] >  LVL_W'(bajo_q)) all_low  = 1'b0;
    end
  end

  // First non-empty input after the last granted one wins.
  always_comb begin
    cand      = '0;
    found     = 1'b0;
    grant_idx = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && !bus.in_empty[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
    grant = 4'b0001 << grant_idx;
  end

  assign any_ready = (bus.in_empty != 4'b1111);
  assign in_flight = p1_valid | (|push_q);
  assign pop_en    = (state == ST_ACTIVE) && !reset && !init && !any_high && any_ready;

  assign bus.in_pop    = pop_en ? grant : 4'b0000;
  assign bus.out_push  = push_q;
  assign bus.out_data  = data_q;
  assign idle          = (state == ST_IDLE);
  assign estado_actual = state;

  assign word_in  = bus.in_data[p1_idx*DATA_W +: DATA_W];
  assign dest_in  = word_in[DATA_W-1 -: 2];
  assign dest_out = data_q[DATA_W-1 -: 2];

  // init outranks every other exit; in ACTIVE the watermark check outranks draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RESET;
      ptr    <= 2'd3;
      alto_q <= '0;
      bajo_q <= '0;
    end else begin
      if (pop_en) ptr <= grant_idx;
      case (state)
        ST_RESET: state <= ST_INIT;
        ST_INIT: begin
          alto_q <= alto;
          bajo_q <= bajo;
          if (!init) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)           state <= ST_INIT;
          else if (any_ready) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)                         state <= ST_INIT;
          else if (any_high)                state <= ST_PAUSE;
          else if (!any_ready && !in_flight) state <= ST_IDLE;
        end
        ST_PAUSE: begin
          if (init)         state <= ST_INIT;
          else if (all_low) state <= any_ready ? ST_ACTIVE : ST_IDLE;
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  // Pop -> capture -> push; never stalls, so in-flight words always drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid  <= 1'b0;
      p1_idx    <= '0;
      push_q    <= '0;
      data_q    <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      cnt_valid <= 1'b0;
      for (int j = 0; j < 4; j++) count[j] <= '0;
    end else begin
      p1_valid <= pop_en;
      p1_idx   <= grant_idx;
      if (p1_valid) begin
        push_q <= 4'b0001 << dest_in;
        data_q <= word_in;
      end else begin
        push_q <= 4'b0000;
      end
      if (|push_q) begin
        count[dest_out] <= count[dest_out] + CNT_W'(1);
        if (|(push_q & bus.out_full)) err <= 1'b1;
      end
      cnt_valid <= req;
      cnt       <= req ? count[idx] : '0;
    end
  end

endmodule

// File: tb/tb_rr_fifo_scheduler.sv
// Bench for rr_fifo_scheduler: queue-based input FIFOs, a transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_rr_fifo_scheduler;
  localparam int DATA_W = 10;
  localparam int LVL_W  = 4;
  localparam int CNT_W  = 5;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] w;
  } flight_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic [2:0]        alto;
  logic [2:0]        bajo;
  logic              req;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_valid;
  logic              idle;
  logic              err;
  logic [3:0]        estado_actual;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] env_q [4][$];
  logic [DATA_W-1:0] mq    [4][$];
  logic [3:0]        pop_seen = 4'b0000;

  flight_t           m_fl [$];
  int                m_state = 0;
  int                m_ptr   = 3;
  int                m_alto  = 0;
  int                m_bajo  = 0;
  int                m_count [4] = '{0, 0, 0, 0};
  int                m_cnt   = 0;
  bit                m_cv    = 1'b0;
  bit                m_err   = 1'b0;
  int                cyc     = 0;

  rr_fifo_scheduler_if #(.DATA_W(DATA_W), .LVL_W(LVL_W)) bus ();

  rr_fifo_scheduler #(.DATA_W(DATA_W), .LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .alto          (alto),
    .bajo          (bajo),
    .bus           (bus),
    .req           (req),
    .idx           (idx),
    .cnt           (cnt),
    .cnt_valid     (cnt_valid),
    .idle          (idle),
    .err           (err),
    .estado_actual (estado_actual)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  // Input FIFO models: registered read data, pops as seen in the previous cycle.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i] && env_q[i].size() > 0)
        bus.in_data[i*DATA_W +: DATA_W] = env_q[i].pop_front();
    end
    for (int i = 0; i < 4; i++) bus.in_empty[i] = (env_q[i].size() == 0);
  end

  // Reference model: checks this cycle's outputs, then advances to the next edge.
  always @(negedge clk) begin : model
    logic [3:0]        e_pop;
    logic [3:0]        e_push;
    logic [DATA_W-1:0] e_data;
    int                g;
    int                c;
    int                d;
    int                lvl;
    bit                hi;
    bit                lo;
    bit                any_in;
    bit                infl;

    any_in = 1'b0;
    for (int i = 0; i < 4; i++) if (mq[i].size() > 0) any_in = 1'b1;
    hi = 1'b0;
    lo = 1'b1;
    for (int j = 0; j < 4; j++) begin
      lvl = int'(bus.out_level[j*LVL_W +: LVL_W]);
      if (lvl >= m_alto) hi = 1'b1;
      if (lvl >  m_bajo) lo = 1'b0;
    end

    g = -1;
    e_pop = 4'b0000;
    if (m_state == 3 && !reset && !init && !hi) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g >= 0) e_pop = 4'b0001 << g;
    end

    e_push = 4'b0000;
    e_data = '0;
    if (m_fl.size() > 0 && m_fl[0].due == cyc) begin
      e_data = m_fl[0].w;
      e_push = 4'b0001 << e_data[DATA_W-1 -: 2];
    end

    checkOutput("state", 32'(estado_actual), 32'(m_state));
    checkOutput("idle", 32'(idle), 32'(m_state == 2));
    checkOutput("in_pop", 32'(bus.in_pop), 32'(e_pop));
    checkOutput("out_push", 32'(bus.out_push), 32'(e_push));
    if (e_push != 0) checkOutput("out_data", 32'(bus.out_data), 32'(e_data));
    checkOutput("err", 32'(err), 32'(m_err));
    checkOutput("cnt_valid", 32'(cnt_valid), 32'(m_cv));
    if (m_cv) checkOutput("cnt", 32'(cnt), 32'(m_cnt));

    pop_seen = bus.in_pop;
    infl = (m_fl.size() > 0);

    if (reset) begin
      m_state = 0;
      m_ptr   = 3;
      m_alto  = 0;
      m_bajo  = 0;
      m_cv    = 1'b0;
      m_cnt   = 0;
      m_err   = 1'b0;
      for (int j = 0; j < 4; j++) m_count[j] = 0;
      m_fl.delete();
    end else begin
      if (req) begin
        m_cnt = m_count[idx];
        m_cv  = 1'b1;
      end else begin
        m_cv  = 1'b0;
      end
      if (e_push != 0) begin
        d = int'(e_data[DATA_W-1 -: 2]);
        if (bus.out_full[d]) m_err = 1'b1;
        m_count[d] = (m_count[d] + 1) % (1 << CNT_W);
        void'(m_fl.pop_front());
      end
      if (g >= 0) begin
        m_fl.push_back('{due: cyc + 2, w: mq[g].pop_front()});
        m_ptr = g;
      end
      case (m_state)
        0: m_state = 1;
        1: begin
          m_alto = int'(alto);
          m_bajo = int'(bajo);
          if (!init) m_state = 2;
        end
        2: if (init) m_state = 1; else if (any_in) m_state = 3;
        3: if (init) m_state = 1; else if (hi) m_state = 4; else if (!any_in && !infl) m_state = 2;
        4: if (init) m_state = 1; else if (lo) m_state = any_in ? 3 : 2;
        default: m_state = 0;
      endcase
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load(input int f, input logic [DATA_W-1:0] w);
    env_q[f].push_back(w);
    mq[f].push_back(w);
  endtask

  task automatic bringUp();
    tick();
    reset = 1'b1;
    init  = 1'b0;
    repeat (2) tick();
    sample();
    checkOutput("rst_state", 32'(estado_actual), 32'd0);
    checkOutput("rst_pop", 32'(bus.in_pop), 32'd0);
    checkOutput("rst_push", 32'(bus.out_push), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    tick();
    reset = 1'b0;
    init  = 1'b1;
    alto  = 3'd5;
    bajo  = 3'd2;
    tick();
    sample();
    checkOutput("init_state", 32'(estado_actual), 32'd1);
    tick();
    init = 1'b0;
    tick();
    sample();
    checkOutput("idle_state", 32'(estado_actual), 32'd2);
    checkOutput("idle_flag", 32'(idle), 32'd1);
  endtask

  task automatic applyStimulus();
    bringUp();

    // single word FIFO1 -> FIFO6
    tick();
    load(1, 10'h205);
    tick(); sample();
    checkOutput("single_pop", 32'(bus.in_pop), 32'b0010);
    tick(); tick(); sample();
    checkOutput("single_push", 32'(bus.out_push), 32'b0100);
    checkOutput("single_data", 32'(bus.out_data), 32'h205);
    tick();
    req = 1'b1;
    idx = 2'd2;
    tick();
    req = 1'b0;
    sample();
    checkOutput("single_cnt_valid", 32'(cnt_valid), 32'd1);
    checkOutput("single_cnt", 32'(cnt), 32'd1);
    checkOutput("single_back_idle", 32'(estado_actual), 32'd2);

    // two words per input, fresh pointer -> 0,1,2,3,0,1,2,3
    bringUp();
    tick();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) load(i, {2'(i), 4'(k), 4'(i)});
    for (int j = 0; j < 10; j++) begin
      tick(); sample();
      if (j < 8) checkOutput("rr_pop", 32'(bus.in_pop), 32'(1) << (j % 4));
      if (j >= 2) checkOutput("rr_push", 32'(bus.out_push), 32'(1) << ((j - 2) % 4));
    end
    tick(); tick(); sample();
    checkOutput("rr_back_idle", 32'(estado_actual), 32'd2);
    tick();
    req = 1'b1;
    idx = 2'd3;
    tick();
    req = 1'b0;
    sample();
    checkOutput("rr_cnt3", 32'(cnt), 32'd2);

    // watermark pause with hysteresis
    tick();
    for (int k = 0; k < 3; k++) load(0, {2'b01, 8'(8'h10 + k)});
    for (int k = 0; k < 3; k++) load(2, {2'b11, 8'(8'h20 + k)});
    tick(); sample();
    checkOutput("pz_pop0", 32'(bus.in_pop), 32'b0001);
    tick(); sample();
    checkOutput("pz_pop2", 32'(bus.in_pop), 32'b0100);
    tick();
    bus.out_level = 16'h0050;
    sample();
    checkOutput("pz_no_pop", 32'(bus.in_pop), 32'd0);
    checkOutput("pz_push_a", 32'(bus.out_push), 32'b0010);
    tick(); sample();
    checkOutput("pz_state", 32'(estado_actual), 32'd4);
    checkOutput("pz_push_b", 32'(bus.out_push), 32'b1000);
    tick();
    bus.out_level = 16'h0030;
    tick(); sample();
    checkOutput("pz_hold", 32'(estado_actual), 32'd4);
    tick();
    bus.out_level = 16'h0020;
    tick(); sample();
    checkOutput("pz_resume", 32'(estado_actual), 32'd3);
    checkOutput("pz_resume_pop", 32'(bus.in_pop), 32'b0001);
    tick();
    bus.out_level = 16'h0000;
    repeat (9) tick();
    sample();
    checkOutput("pz_drained", 32'(estado_actual), 32'd2);

    // push into a full FIFO4
    tick();
    load(3, 10'h011);
    bus.out_full = 4'b0001;
    tick(); tick(); tick(); sample();
    checkOutput("ovf_push", 32'(bus.out_push), 32'b0001);
    checkOutput("ovf_err_before", 32'(err), 32'd0);
    tick(); sample();
    checkOutput("ovf_err", 32'(err), 32'd1);
    tick();
    bus.out_full = 4'b0000;
    repeat (5) tick();
    sample();
    checkOutput("ovf_sticky", 32'(err), 32'd1);

    // reset with two words in flight
    tick();
    load(0, 10'h1AA);
    load(1, 10'h2BB);
    tick(); tick(); tick();
    reset = 1'b1;
    sample();
    checkOutput("mid_last_push", 32'(bus.out_push), 32'b0010);
    tick(); sample();
    checkOutput("mid_no_push", 32'(bus.out_push), 32'd0);
    checkOutput("mid_state", 32'(estado_actual), 32'd0);
    checkOutput("mid_err_clr", 32'(err), 32'd0);
    tick();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      req = 1'b1;
      idx = 2'(j);
      tick();
      req = 1'b0;
      sample();
      checkOutput("mid_cnt_valid", 32'(cnt_valid), 32'd1);
      checkOutput("mid_cnt_zero", 32'(cnt), 32'd0);
    end
    repeat (3) tick();
  endtask

  initial begin
    reset         = 1'b1;
    init          = 1'b0;
    alto          = 3'd0;
    bajo          = 3'd0;
    req           = 1'b0;
    idx           = 2'd0;
    bus.out_level = '0;
    bus.out_full  = '0;
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
